sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Bus-side SRAM controller: converts single-word read_op/write_op requests into timed async-SRAM strobe sequences.
- Sits directly downstream of the bus master and upstream of the SRAM pins; the fake SRAM model attaches to its pin side in simulation.
- Multi-cycle FSM with programmable wait states, busy/done handshake, registered read data.

Parameters:
- ADDR_W, 20, SRAM word-address width; bus byte address is ADDR_W+2 bits.
- DATA_W, 32, data word width; fixed 4 byte lanes.
- WAIT_CYCLES, 1, extra cycles the read-access/write-pulse phase is held (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- bus_addr  in  ADDR_W+2  byte address; bits [1:0] ignored
- read_op  in  1  read request (level)
- write_op  in  1  write request (level)
- bus_data_write  in  DATA_W  write data
- bus_be  in  4  byte-lane enables for writes, bit i = byte i
- bus_data_read  out  DATA_W  registered read data
- busy  out  1  high while not IDLE
- done  out  1  one-cycle completion pulse
- sram_addr  out  ADDR_W  SRAM word address
- sram_data_i  in  DATA_W  data from SRAM
- sram_data_o  out  DATA_W  data to SRAM
- sram_data_oe  out  1  tristate enable for sram_data_o
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes
- sram_be_n  out  4  active-low byte enables

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; bus_data_read=0, busy=0, done=0, sram_addr=0, sram_data_o=0, sram_data_oe=0, ce_n=oe_n=we_n=1, sram_be_n=4'hF. Reset mid-access aborts it at that same edge; done is not issued.
- All outputs are registered.
- IDLE: request sampled each edge; write_op has priority if both high. On accept: latch addr=bus_addr[ADDR_W+1:2], wdata, be; busy=1 from next cycle.
- RD: ce_n=0, oe_n=0, be_n=0, oe=0; held WAIT_CYCLES+1 cycles. At the final RD edge, sram_data_i is captured into bus_data_read; go to DONE.
- WR_SETUP (1 cycle): ce_n=0, we_n=1, oe=1, data driven, be_n=~be.
- WR_PULSE (WAIT_CYCLES+1 cycles): we_n=0.
- WR_HOLD (1 cycle): we_n=1, data/oe/ce held; then DONE.
- DONE (1 cycle): done=1, all strobes deasserted, oe=0, busy=0; next state IDLE. New requests are accepted only in IDLE, so the earliest next access starts the cycle after DONE.
- Latency from accept edge to done-high cycle: read WAIT_CYCLES+2, write WAIT_CYCLES+4.
- Requests arriving while busy are ignored; the master holds the request until done and deasserts it in the done cycle. A request still high in IDLE after DONE is treated as a new access.
- sram_data_oe and sram_oe_n are never both active (oe=1 only in WR_* states).
- Wait counter is 4 bits and reloads on every phase entry; WAIT_CYCLES=0 gives single-cycle phases.
- bus_data_read holds its value until the next read completes; writes do not alter it.

Optional Feature:
- Macro SRAM_CTRL_BYTE_WRITE_EN.
- Defined: sram_be_n=~bus_be (latched) during the write phases. bus_be==0 completes the normal write sequence but never asserts we_n, and done is still issued.
- Undefined: bus_be is ignored; all writes use sram_be_n=4'h0.
- Reads always use be_n=4'h0 regardless of the macro.

Test Plan:
- Reset: hold rst=0 for 3 cycles with read_op=1 -> all outputs at reset values, busy=0, no strobe ever asserted.
- Read, WAIT_CYCLES=1: SRAM word 0x10 preloaded 0xDEADBEEF; read_op=1, bus_addr=0x40 -> ce_n/oe_n low 2 cycles, sram_addr=0x10, done on 3rd cycle after accept, bus_data_read=0xDEADBEEF.
- Write: bus_addr=0x8, data=0x12345678, be=4'hF -> we_n low exactly 2 cycles, data stable from setup through hold, SRAM word 2 = 0x12345678, done 5 cycles after accept.
- Byte write (macro defined): word 2=0x12345678, write 0xAABBCCDD be=4'b0101 -> word becomes 0x12BB56DD. With macro undefined -> 0xAABBCCDD.
- Conflict/back-to-back: read_op=write_op=1 -> write performed. Requests held through busy are ignored; release in the done cycle. A second read issued the cycle after DONE is accepted, with no extra idle gap.
- Abort: rst=0 during WR_PULSE -> we_n=1 and oe=0 at that edge, done never pulses, next read returns correct data.

Source files
------------

// File: rtl/sram_ctrl.sv
// Single-word bus to async-SRAM strobe sequencer with programmable wait states.
// Optional macro SRAM_CTRL_BYTE_WRITE_EN: honour bus_be on writes (otherwise all four lanes are written).
module sram_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+1:0] bus_addr,
  input  logic              read_op,
  input  logic              write_op,
  input  logic [DATA_W-1:0] bus_data_write,
  input  logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_data_read,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          be_q, be_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_q, oe_d;
  logic [3:0]          be_n_q, be_n_d;
  logic [3:0]          accept_be;

`ifdef SRAM_CTRL_BYTE_WRITE_EN
  assign accept_be = bus_be;
  logic unused_bits;
  assign unused_bits = ^bus_addr[1:0];
`else
  assign accept_be = 4'hF;
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_be};
`endif

  // Next-state and next-output logic; every output is a register fed from state_d.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;

    case (state_q)
      S_IDLE: begin
        if (write_op) begin
          state_d = S_WR_SETUP;
          addr_d  = bus_addr[ADDR_W+1:2];
          wdata_d = bus_data_write;
          be_d    = accept_be;
        end else if (read_op) begin
          state_d = S_RD;
          addr_d  = bus_addr[ADDR_W+1:2];
          cnt_d   = WAIT_LOAD;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          rdata_d = sram_data_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WAIT_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    oe_d   = 1'b0;
    be_n_d = 4'hF;
    busy_d = 1'b0;
    done_d = 1'b0;

    case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
        busy_d = 1'b1;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_d = 1'b0;
        oe_d   = 1'b1;
        be_n_d = ~be_d;
        busy_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d = 1'b0;
        oe_d   = 1'b1;
        be_n_d = ~be_d;
        busy_d = 1'b1;
        // A write with no lanes enabled runs the full sequence without a strobe.
        we_n_d = ~(|be_d);
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      be_n_q  <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      be_n_q  <= be_n_d;
    end
  end

  assign bus_data_read = rdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sram_addr     = addr_q;
  assign sram_data_o   = wdata_q;
  assign sram_data_oe  = oe_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_be_n     = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: fake async SRAM on the pin side, transaction-level model checked every cycle.
module tb_sram_ctrl;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int W  = 1;
  localparam int RD_LAT = W + 2;
  localparam int WR_LAT = W + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW+1:0] bus_addr;
  logic          read_op, write_op;
  logic [DW-1:0] bus_data_write;
  logic [3:0]    bus_be;
  logic [DW-1:0] bus_data_read;
  logic          busy, done;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_i, sram_data_o;
  logic          sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .read_op(read_op), .write_op(write_op),
    .bus_data_write(bus_data_write), .bus_be(bus_be), .bus_data_read(bus_data_read),
    .busy(busy), .done(done), .sram_addr(sram_addr), .sram_data_i(sram_data_i),
    .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                       input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [3:0] eff_be(input logic [3:0] be);
`ifdef SRAM_CTRL_BYTE_WRITE_EN
    return be;
`else
    return 4'hF;
`endif
  endfunction

  // Fake asynchronous SRAM: combinational read, write while ce_n/we_n are low at a clock edge.
  logic [31:0] fake_mem [256];
  logic        fake_init = 1'b0;
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? fake_mem[sram_addr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (!fake_init) begin
      for (int i = 0; i < 256; i++) fake_mem[i] <= init_word(i);
      fake_init <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) fake_mem[sram_addr[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
    end
  end

  // Transaction model: cycles elapsed since the accepting edge, plus expected memory and read data.
  logic [31:0] exp_mem [256];
  logic        exp_init = 1'b0;
  logic        m_valid  = 1'b0;
  int          m_cyc;
  logic        m_wr;
  logic [3:0]  m_be;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (!exp_init) begin
      for (int i = 0; i < 256; i++) exp_mem[i] <= init_word(i);
      exp_init <= 1'b1;
    end
    if (!rst) begin
      m_valid <= 1'b1;
      m_cyc   <= 0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else if (m_cyc == 0) begin
      if (write_op || read_op) begin
        m_cyc  <= 1;
        m_wr   <= write_op;
        m_addr <= bus_addr[AW+1:2];
        if (write_op) begin
          m_wdata <= bus_data_write;
          m_be    <= eff_be(bus_be);
        end
      end
    end else if (m_cyc == (m_wr ? WR_LAT : RD_LAT)) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == (m_wr ? WR_LAT : RD_LAT)) begin
        if (m_wr) exp_mem[m_addr[7:0]] <= merge(exp_mem[m_addr[7:0]], m_wdata, m_be);
        else      m_rdata <= exp_mem[m_addr[7:0]];
      end
    end
  end

  always @(negedge clk) begin : compare
    logic e_ce_n, e_oe_n, e_we_n, e_oe, e_busy, e_done;
    logic [3:0] e_be_n;
    if (m_valid) begin
      e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_oe = 1'b0;
      e_be_n = 4'hF; e_busy = 1'b0; e_done = 1'b0;
      if (m_cyc != 0) begin
        if (m_cyc == (m_wr ? WR_LAT : RD_LAT)) begin
          e_done = 1'b1;
        end else begin
          e_busy = 1'b1;
          e_ce_n = 1'b0;
          if (!m_wr) begin
            e_oe_n = 1'b0;
            e_be_n = 4'h0;
          end else begin
            e_oe   = 1'b1;
            e_be_n = ~m_be;
            if (m_cyc >= 2 && m_cyc <= W + 2 && m_be != 4'h0) e_we_n = 1'b0;
          end
        end
      end
      chk("strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, sram_be_n, busy, done},
          {e_ce_n, e_oe_n, e_we_n, e_oe, e_be_n, e_busy, e_done});
      chk("sram_addr", sram_addr, m_addr);
      chk("sram_data_o", sram_data_o, m_wdata);
      chk("bus_data_read", bus_data_read, m_rdata);
    end
  end

  task automatic do_op(input bit wr, input bit both, input logic [AW+1:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output int lat, output int we_low);
    int  n;
    bit  seen;
    @(posedge clk); #1;
    bus_addr = a; bus_data_write = d; bus_be = be;
    write_op = wr | both;
    read_op  = !wr | both;
    n = 0; we_low = 0; seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (!sram_we_n) we_low++;
      if (done) seen = 1;
    end
    read_op = 1'b0;
    write_op = 1'b0;
    lat = n - 1;
    chk("done_seen", seen, 1'b1);
    $display("op %s addr=%0h wdata=%0h be=%0h lat=%0d we_low=%0d rdata=%0h",
             (wr | both) ? "WR" : "RD", a, d, be, lat, we_low, bus_data_read);
  endtask

  initial begin
    int lat, wl, n;
    bit found;
    rst = 1'b0; read_op = 1'b1; write_op = 1'b0;
    bus_addr = '0; bus_data_write = '0; bus_be = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ce_n", sram_ce_n, 1'b1);
    chk("rst_be_n", sram_be_n, 4'hF);
    rst = 1'b1; read_op = 1'b0;
    $display("reset released");

    do_op(1'b0, 1'b0, 22'h40, 32'h0, 4'h0, lat, wl);
    chk("rd_lat", lat, 3);
    chk("rd_data", bus_data_read, 32'hDEADBEEF);
    chk("rd_addr", sram_addr, 20'h10);

    do_op(1'b1, 1'b0, 22'h8, 32'h12345678, 4'hF, lat, wl);
    chk("wr_lat", lat, 5);
    chk("wr_we_low", wl, 2);
    chk("wr_mem", fake_mem[2], 32'h12345678);
    chk("wr_keeps_rdata", bus_data_read, 32'hDEADBEEF);

    do_op(1'b1, 1'b0, 22'h8, 32'hAABBCCDD, 4'b0101, lat, wl);
`ifdef SRAM_CTRL_BYTE_WRITE_EN
    chk("bw_mem", fake_mem[2], 32'h12BB56DD);
`else
    chk("bw_mem", fake_mem[2], 32'hAABBCCDD);
`endif

    do_op(1'b0, 1'b1, 22'hC, 32'h0BADF00D, 4'hF, lat, wl);
    chk("conflict_lat", lat, 5);
    chk("conflict_mem", fake_mem[3], 32'h0BADF00D);

    do_op(1'b0, 1'b0, 22'hC, 32'h0, 4'h0, lat, wl);
    chk("b2b1_lat", lat, 3);
    chk("b2b1_data", bus_data_read, 32'h0BADF00D);
    do_op(1'b0, 1'b0, 22'h40, 32'h0, 4'h0, lat, wl);
    chk("b2b2_lat", lat, 3);
    chk("b2b2_data", bus_data_read, 32'hDEADBEEF);

    do_op(1'b1, 1'b0, 22'h10, 32'h11111111, 4'h0, lat, wl);
    chk("be0_lat", lat, 5);
`ifdef SRAM_CTRL_BYTE_WRITE_EN
    chk("be0_we_low", wl, 0);
    chk("be0_mem", fake_mem[4], 32'hA5A50004);
`else
    chk("be0_we_low", wl, 2);
    chk("be0_mem", fake_mem[4], 32'h11111111);
`endif

    // Abort a write in its first strobe cycle.
    @(posedge clk); #1;
    bus_addr = 22'h100; bus_data_write = 32'h55555555; bus_be = 4'hF; write_op = 1'b1;
    n = 0; found = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (!sram_we_n) found = 1;
    end
    chk("abort_pulse_seen", found, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; write_op = 1'b0;
    @(negedge clk);
    chk("abort_we_n", sram_we_n, 1'b1);
    chk("abort_oe", sram_data_oe, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    $display("abort write addr=100");

    do_op(1'b0, 1'b0, 22'h40, 32'h0, 4'h0, lat, wl);
    chk("post_abort_lat", lat, 3);
    chk("post_abort_data", bus_data_read, 32'hDEADBEEF);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
